// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA responder and its beat FIFO.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        IRQ     = 2'd3
    } state_t;

    localparam logic [1:0] IRQ_NONE = 2'b00;
    localparam logic [1:0] IRQ_DONE = 2'b01;
    localparam logic [1:0] IRQ_ERR  = 2'b10;

    localparam logic [31:0] CMD_ADDR_DEFAULT = 32'hFFFF_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

endpackage

// File: rtl/dma_fifo.sv
// First-word-fall-through beat FIFO with synchronous flush; head is read
// straight from registered storage at the read pointer.
module dma_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  beat_t din,
    output logic  full,
    output logic  empty,
    output beat_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    beat_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dma_responder.sv
// Target-side DMA engine: takes a command beat plus a burst of address/data
// beats from the CPU, buffers them, drains them to a device valid/ready port.
module dma_responder
    import dma_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] CMD_ADDR = CMD_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] memAddr,
    input  logic [31:0] memDataOut,
    input  logic        ack,
    output logic        nextTransaction,
    output logic [1:0]  Interrupt,
    output logic        dev_valid,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_data,
    input  logic        dev_ready
);

    state_t      state;
    logic [15:0] remaining;
    logic [15:0] cmd_len;
    logic        accept;
    logic        is_cmd;
    logic        err;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    beat_t       head;
    beat_t       din;

    assign cmd_len = memDataOut[15:0];
    assign din     = '{addr: memAddr, data: memDataOut};

    always_comb begin
        nextTransaction = (state == IDLE) || ((state == COLLECT) && !full);
        accept          = en && nextTransaction;
        is_cmd          = (memAddr == CMD_ADDR);
        err             = 1'b0;
        // en during IRQ is deliberately harmless; everywhere else a refused beat is an error.
        if (state != IRQ) begin
            if (en && !nextTransaction) begin
                err = 1'b1;
            end else if (accept) begin
                case (state)
                    IDLE:    err = !is_cmd || (cmd_len == 16'd0);
                    COLLECT: err = is_cmd;
                    default: err = 1'b0;
                endcase
            end
        end
        push = accept && (state == COLLECT) && !is_cmd;
    end

    assign pop       = dev_valid && dev_ready;
    assign dev_valid = !empty;
    assign dev_addr  = dev_valid ? head.addr : 32'd0;
    assign dev_data  = dev_valid ? head.data : 32'd0;

    dma_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (err),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            Interrupt <= IRQ_NONE;
        end else if (err) begin
            state     <= IRQ;
            remaining <= '0;
            Interrupt <= IRQ_ERR;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        remaining <= cmd_len;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (push) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // An empty FIFO means dev_valid is low, so no pop can be in flight.
                    if (empty) begin
                        Interrupt <= IRQ_DONE;
                        state     <= IRQ;
                    end
                end
                IRQ: begin
                    if (ack) begin
                        Interrupt <= IRQ_NONE;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_responder.sv
// Directed bench for dma_responder with a beat scoreboard on the device port.
module tb_dma_responder;
    import dma_pkg::*;

    localparam logic [31:0] CMD = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] memAddr;
    logic [31:0] memDataOut;
    logic        ack;
    logic        nextTransaction;
    logic [1:0]  Interrupt;
    logic        dev_valid;
    logic [31:0] dev_addr;
    logic [31:0] dev_data;
    logic        dev_ready;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic        stalled = 1'b0;
    logic [63:0] held = '0;

    always #5 clk = ~clk;

    dma_responder #(
        .DEPTH    (4),
        .CMD_ADDR (CMD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .memAddr         (memAddr),
        .memDataOut      (memDataOut),
        .ack             (ack),
        .nextTransaction (nextTransaction),
        .Interrupt       (Interrupt),
        .dev_valid       (dev_valid),
        .dev_addr        (dev_addr),
        .dev_data        (dev_data),
        .dev_ready       (dev_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input bit expect_push);
        en         = 1'b1;
        memAddr    = a;
        memDataOut = d;
        if (expect_push) sb.push_back({a, d});
        tick();
        en = 1'b0;
    endtask

    task automatic wait_irq(input string tag, input logic [1:0] code);
        for (int i = 0; i < 20 && Interrupt !== code; i++) tick();
        chk(tag, 64'(Interrupt), 64'(code));
    endtask

    task automatic wait_nt(input string tag);
        for (int i = 0; i < 20 && nextTransaction !== 1'b1; i++) tick();
        chk(tag, 64'(nextTransaction), 64'd1);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_irq", 64'(Interrupt), 64'(IRQ_NONE));
        chk("ack_nt", 64'(nextTransaction), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_nt"}, 64'(nextTransaction), 64'd1);
        chk({tag, "_irq"}, 64'(Interrupt), 64'(IRQ_NONE));
        chk({tag, "_valid"}, 64'(dev_valid), 64'd0);
        chk({tag, "_addr"}, 64'(dev_addr), 64'd0);
        chk({tag, "_data"}, 64'(dev_data), 64'd0);
    endtask

    // Device-side monitor: in-order beat delivery and stall stability.
    always @(negedge clk) begin
        if (rst_n && stalled && dev_valid)
            chk("stall_stable", {dev_addr, dev_data}, held);
        if (rst_n && dev_valid && dev_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL beat_unexpected observed %0h expected none", {dev_addr, dev_data});
            end
            if (sb.size() != 0) chk("beat_order", {dev_addr, dev_data}, sb.pop_front());
        end
        stalled = rst_n && dev_valid && !dev_ready;
        held    = {dev_addr, dev_data};
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        ack        = 1'b0;
        memAddr    = '0;
        memDataOut = '0;
        dev_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic burst of three with the device always ready.
        dev_ready = 1'b1;
        beat(CMD, 32'd3, 1'b0);
        chk("t1_no_early_valid", 64'(dev_valid), 64'd0);
        beat(32'h100, 32'hA, 1'b1);
        chk("t1_latency_valid", 64'(dev_valid), 64'd1);
        chk("t1_latency_addr", 64'(dev_addr), 64'h100);
        beat(32'h104, 32'hB, 1'b1);
        beat(32'h108, 32'hC, 1'b1);
        chk("t1_drain_nt", 64'(nextTransaction), 64'd0);
        wait_irq("t1_done", IRQ_DONE);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        ack_pulse();

        // Overrun: en held while the FIFO is full.
        dev_ready = 1'b0;
        beat(CMD, 32'd6, 1'b0);
        for (int i = 0; i < 4; i++) beat(32'h200 + 32'(4 * i), 32'h20 + 32'(i), 1'b1);
        chk("t2_full_nt", 64'(nextTransaction), 64'd0);
        chk("t2_full_valid", 64'(dev_valid), 64'd1);
        beat(32'h210, 32'h24, 1'b0);
        sb.delete();
        chk("t2_err_irq", 64'(Interrupt), 64'(IRQ_ERR));
        chk("t2_flush_valid", 64'(dev_valid), 64'd0);
        ack_pulse();

        // Flow-controlled burst of six through a four-deep FIFO.
        beat(CMD, 32'd6, 1'b0);
        for (int i = 0; i < 4; i++) beat(32'h300 + 32'(4 * i), 32'h30 + 32'(i), 1'b1);
        chk("t3_full_nt", 64'(nextTransaction), 64'd0);
        dev_ready = 1'b1;
        tick();
        dev_ready = 1'b0;
        chk("t3_one_slot_nt", 64'(nextTransaction), 64'd1);
        chk("t3_one_drained", 64'(sb.size()), 64'd3);
        beat(32'h310, 32'h34, 1'b1);
        chk("t3_refull_nt", 64'(nextTransaction), 64'd0);
        dev_ready = 1'b1;
        wait_nt("t3_wait_nt");
        beat(32'h314, 32'h35, 1'b1);
        wait_irq("t3_done", IRQ_DONE);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);
        ack_pulse();

        // Protocol errors from IDLE.
        beat(32'h200, 32'h55, 1'b0);
        chk("t4_data_idle_irq", 64'(Interrupt), 64'(IRQ_ERR));
        chk("t4_data_idle_valid", 64'(dev_valid), 64'd0);
        ack_pulse();
        beat(CMD, 32'd0, 1'b0);
        chk("t4_len0_irq", 64'(Interrupt), 64'(IRQ_ERR));
        ack_pulse();

        // Push/pop overlap with dev_ready toggling 1,0,1.
        dev_ready = 1'b0;
        beat(CMD, 32'd4, 1'b0);
        beat(32'h400, 32'h1, 1'b1);
        beat(32'h404, 32'h2, 1'b1);
        dev_ready = 1'b1;
        beat(32'h408, 32'h3, 1'b1);
        chk("t5_overlap_count", 64'(sb.size()), 64'd2);
        dev_ready = 1'b0;
        beat(32'h40C, 32'h4, 1'b1);
        chk("t5_stall_count", 64'(sb.size()), 64'd3);
        tick();
        tick();
        chk("t5_stall_head", 64'(dev_addr), 64'h404);
        dev_ready = 1'b1;
        wait_irq("t5_done", IRQ_DONE);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        ack_pulse();

        // Asynchronous reset in the middle of a burst.
        dev_ready = 1'b0;
        beat(CMD, 32'd4, 1'b0);
        beat(32'h500, 32'h50, 1'b1);
        beat(32'h504, 32'h51, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_midreset");
        sb.delete();
        tick();
        rst_n     = 1'b1;
        dev_ready = 1'b1;
        beat(CMD, 32'd1, 1'b0);
        beat(32'h600, 32'h77, 1'b1);
        wait_irq("t6_done", IRQ_DONE);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        ack_pulse();

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
